ir_prefetch: RTL and testbench

- Parametrised instruction register with a small prefetch queue, for the PIC10F200-class core and its wider variants.
- Sits between the program memory read port and the control unit.
- Program words are accepted under a valid/ready handshake and buffered in a DEPTH-entry FIFO.
- The control unit advances the instruction register with ir_load and can annul the next instruction (skip) or discard all prefetched words on a branch (flush).

---
 rtl/ir_prefetch.sv | 92 +++++++++
 tb/tb_ir_prefetch.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ir_prefetch.sv
// Instruction register fed by a DEPTH-entry prefetch FIFO from program memory.
// The control unit advances with ir_load, annuls with skip, and discards everything with flush.
module ir_prefetch #(
    parameter int             IW       = 12,
    parameter int             DEPTH    = 2,
    parameter logic [IW-1:0]  NOP_WORD = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fetch_valid,
    input  logic [IW-1:0]              program_bus,
    output logic                       fetch_ready,
    input  logic                       ir_load,
    input  logic                       skip,
    input  logic                       flush,
    output logic [IW-1:0]              ir_bus,
    output logic                       ir_valid,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);

    logic [IW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_skip_pending;
    logic [IW-1:0] r_ir;
    logic          r_ir_valid;

    logic w_push;
    logic w_store;
    logic w_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        fetch_ready = (r_count < DEPTH_C) && !flush;
        w_push      = fetch_valid && fetch_ready;
        w_store     = w_push && !r_skip_pending;
        w_pop       = ir_load && (r_count != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr         <= '0;
            r_rptr         <= '0;
            r_count        <= '0;
            r_skip_pending <= 1'b0;
            r_ir           <= NOP_WORD;
            r_ir_valid     <= 1'b0;
        end else if (flush) begin
            r_wptr         <= '0;
            r_rptr         <= '0;
            r_count        <= '0;
            r_skip_pending <= 1'b0;
            r_ir           <= NOP_WORD;
            r_ir_valid     <= 1'b0;
        end else begin
            if (w_store) begin
                r_mem[r_wptr] <= program_bus;
                r_wptr        <= ptr_inc(r_wptr);
            end
            if (w_push && r_skip_pending)
                r_skip_pending <= 1'b0;
            // A skip on an empty queue arms skip_pending; it wins over a same-cycle clear
            if (ir_load) begin
                if (r_count != '0) begin
                    r_ir       <= skip ? NOP_WORD : r_mem[r_rptr];
                    r_ir_valid <= 1'b1;
                    r_rptr     <= ptr_inc(r_rptr);
                end else begin
                    r_ir       <= NOP_WORD;
                    r_ir_valid <= skip;
                    if (skip)
                        r_skip_pending <= 1'b1;
                end
            end
            r_count <= r_count + CW'(w_store) - CW'(w_pop);
        end
    end

    assign ir_bus   = r_ir;
    assign ir_valid = r_ir_valid;
    assign count    = r_count;

endmodule

// File: tb/tb_ir_prefetch.sv
// Directed checks on a DEPTH=2 instance plus a queue-model scoreboard on a DEPTH=3, IW=14 instance.
module tb_ir_prefetch;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    logic        a_fv, a_fr, a_ld, a_sk, a_fl, a_iv;
    logic [11:0] a_pb, a_ir;
    logic [1:0]  a_cnt;

    logic        b_fv, b_fr, b_ld, b_sk, b_fl, b_iv;
    logic [13:0] b_pb, b_ir;
    logic [1:0]  b_cnt;

    ir_prefetch #(.IW(12), .DEPTH(2), .NOP_WORD(12'h000)) u_a (
        .clk(clk), .rst(rst), .fetch_valid(a_fv), .program_bus(a_pb), .fetch_ready(a_fr),
        .ir_load(a_ld), .skip(a_sk), .flush(a_fl), .ir_bus(a_ir), .ir_valid(a_iv), .count(a_cnt)
    );

    ir_prefetch #(.IW(14), .DEPTH(3), .NOP_WORD(14'h0000)) u_b (
        .clk(clk), .rst(rst), .fetch_valid(b_fv), .program_bus(b_pb), .fetch_ready(b_fr),
        .ir_load(b_ld), .skip(b_sk), .flush(b_fl), .ir_bus(b_ir), .ir_valid(b_iv), .count(b_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [11:0] ir, input logic iv, input logic [1:0] cnt);
        chk({tag, "_ir"}, a_ir, ir);
        chk({tag, "_iv"}, a_iv, iv);
        chk({tag, "_cnt"}, a_cnt, cnt);
    endtask

    // push/load pattern for instance B: bit0 = fetch_valid, bit1 = ir_load
    int pat [30] = '{1,1,1,3,1,3,2,2,2,3,3,3,1,1,3,3,2,2,2,2,1,3,1,1,1,3,2,2,2,0};

    logic [13:0] m_q   [$];
    logic [13:0] exp_q [$];
    logic [13:0] m_ir;
    logic        m_iv;
    logic [13:0] word;
    logic        acc, popping;

    initial begin
        rst = 1'b1;
        a_fv = 0; a_ld = 0; a_sk = 0; a_fl = 0; a_pb = '0;
        b_fv = 0; b_ld = 0; b_sk = 0; b_fl = 0; b_pb = '0;
        step();
        step();
        chk_a("reset", 12'h000, 1'b0, 2'd0);
        chk("reset_fr", a_fr, 1);
        chk("reset_b_cnt", b_cnt, 0);
        rst = 1'b0;

        // fill to full; third word is held off
        a_fv = 1; a_pb = 12'hA05; step();
        a_pb = 12'h1F3; step();
        chk("fill_cnt", a_cnt, 2);
        chk("fill_fr", a_fr, 0);
        a_pb = 12'h0C7; step();
        chk("holdoff_cnt", a_cnt, 2);
        a_fv = 0; a_ld = 1; step();
        chk_a("pop1", 12'hA05, 1'b1, 2'd1);
        step();
        chk_a("pop2", 12'h1F3, 1'b1, 2'd0);

        // push + load on empty: no bypass
        a_fv = 1; a_pb = 12'h2A0; step();
        chk_a("nobypass", 12'h000, 1'b0, 2'd1);
        a_fv = 0; step();
        chk_a("nobypass_next", 12'h2A0, 1'b1, 2'd0);
        a_ld = 0;

        // skip with a non-empty queue
        a_fv = 1; a_pb = 12'h305; step();
        a_pb = 12'h0A0; step();
        a_fv = 0; a_ld = 1; a_sk = 1; step();
        chk_a("skip", 12'h000, 1'b1, 2'd1);
        a_sk = 0; step();
        chk_a("skip_next", 12'h0A0, 1'b1, 2'd0);

        // skip on empty queue drops the next pushed word
        a_sk = 1; step();
        chk_a("skip_empty", 12'h000, 1'b1, 2'd0);
        a_ld = 0; a_sk = 0;
        a_fv = 1; a_pb = 12'h0E5; step();
        chk("drop_cnt", a_cnt, 0);
        a_pb = 12'h0F6; step();
        chk("after_drop_cnt", a_cnt, 1);
        a_fv = 0; a_ld = 1; step();
        chk_a("after_drop", 12'h0F6, 1'b1, 2'd0);
        a_ld = 0;

        // flush with full queue, valid fetch and ir_load all active
        a_fv = 1; a_pb = 12'hA05; step();
        a_pb = 12'hB11; step();
        a_pb = 12'hC22; a_ld = 1; step();
        a_ld = 0; step();
        chk_a("prefl", 12'hA05, 1'b1, 2'd2);
        a_pb = 12'h123; a_ld = 1; a_fl = 1; #1;
        chk("flush_fr", a_fr, 0);
        step();
        chk_a("flush", 12'h000, 1'b0, 2'd0);
        a_fl = 0; a_ld = 0; a_pb = 12'h456; step();
        a_fv = 0; a_ld = 1; step();
        chk_a("post_flush", 12'h456, 1'b1, 2'd0);

        // arm skip_pending with a word queued, then reset mid-stream
        a_fv = 1; a_pb = 12'h0AA; a_sk = 1; step();
        chk_a("arm", 12'h000, 1'b1, 2'd1);
        a_fv = 0; a_ld = 0; a_sk = 0; rst = 1; step();
        rst = 0;
        chk_a("midrst", 12'h000, 1'b0, 2'd0);
        chk("midrst_fr", a_fr, 1);
        a_fv = 1; a_pb = 12'h0BB; step();
        chk("rst_clears_pending", a_cnt, 1);
        a_fv = 0; a_ld = 1; step();
        chk_a("after_rst", 12'h0BB, 1'b1, 2'd0);
        a_ld = 0;

        // DEPTH=3 scoreboard run
        m_ir = '0; m_iv = 0; word = 14'h2001;
        for (int c = 0; c < 30; c++) begin
            b_fv = (pat[c] & 1) != 0;
            b_ld = (pat[c] & 2) != 0;
            b_pb = word;
            #1;
            chk("b_fr", b_fr, (m_q.size() < 3) ? 1 : 0);
            acc     = b_fv && (m_q.size() < 3);
            popping = b_ld && (m_q.size() > 0);
            if (popping) begin
                exp_q.push_back(m_q[0]);
                m_iv = 1'b1;
            end else if (b_ld) begin
                m_ir = '0;
                m_iv = 1'b0;
            end
            step();
            if (popping) begin
                void'(m_q.pop_front());
                m_ir = exp_q.pop_front();
            end
            if (acc) begin
                m_q.push_back(word);
                word = word + 14'h0123;
            end
            chk("b_ir", b_ir, m_ir);
            chk("b_iv", b_iv, m_iv);
            chk("b_cnt", b_cnt, m_q.size());
        end
        b_fv = 0; b_ld = 0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
